// File: rtl/mux_pkg.sv
// Shared constants for the N-input registered multiplexer.
package mux_pkg;

    // Grant source selection for mux_rr_nbyw.
    localparam int unsigned MODE_SEL = 0;  // grant follows external sel
    localparam int unsigned MODE_RR  = 1;  // grant from fair round-robin arbiter

endpackage

// File: rtl/rr_arbiter_n.sv
// Rotating-priority arbiter: scans requests starting at ptr and wrapping at NUM_IN.
// Also produces the next pointer value so the owner only has to register it.
module rr_arbiter_n
    import mux_pkg::*;
#(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              en,
    output logic [SEL_W-1:0]  grant,
    output logic              gvalid,
    output logic [SEL_W-1:0]  ptr_nxt
);

    // First requester at or after ptr, in circular order modulo NUM_IN.
    always_comb begin
        int unsigned idx;
        grant  = '0;
        gvalid = 1'b0;
        idx    = 0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            idx = (32'(ptr) + k) % NUM_IN;
            if (!gvalid && req[idx]) begin
                gvalid = 1'b1;
                grant  = SEL_W'(idx);
            end
        end
    end

    // Pointer moves just past the winner on a transfer; wraps at NUM_IN, not 2^SEL_W.
    always_comb begin
        ptr_nxt = ptr;
        if (en) begin
            ptr_nxt = (grant == SEL_W'(NUM_IN - 1)) ? '0 : grant + SEL_W'(1);
        end
    end

endmodule

// File: rtl/mux_rr_nbyw.sv
// N-input, W-bit multiplexer with valid/ready per input and one output register stage.
// Grant comes from an external select (MODE_SEL) or a round-robin arbiter (MODE_RR).
module mux_rr_nbyw
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned MODE   = 1,
    localparam int unsigned SEL_W = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_src
);

    logic             load_en;
    logic             gvalid;
    logic             xfer;
    logic [SEL_W-1:0] grant;
    logic [WIDTH-1:0] sel_data;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_src_q, out_src_d;

    // Register can take a word while empty or while being drained this cycle.
    assign load_en = !out_valid_q || out_ready;
    assign xfer    = !rst && load_en && gvalid;

    if (MODE == MODE_RR) begin : g_rr
        logic [SEL_W-1:0] ptr_q, ptr_d;
        logic             unused_sel;

        assign unused_sel = ^sel;

        rr_arbiter_n #(
            .NUM_IN (NUM_IN),
            .SEL_W  (SEL_W)
        ) u_arb (
            .req     (in_valid),
            .ptr     (ptr_q),
            .en      (xfer),
            .grant   (grant),
            .gvalid  (gvalid),
            .ptr_nxt (ptr_d)
        );

        // Round-robin pointer; only advances on a completed transfer.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= ptr_d;
            end
        end
    end else begin : g_sel
        assign grant = sel;

        // Out-of-range sel matches no input and so never grants.
        always_comb begin
            gvalid = 1'b0;
            for (int i = 0; i < int'(NUM_IN); i++) begin
                if (sel == SEL_W'(i)) begin
                    gvalid = in_valid[i];
                end
            end
        end
    end

    // One-hot ready to the granted input; forced low during reset.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < int'(NUM_IN); i++) begin
            in_ready[i] = xfer && (grant == SEL_W'(i));
        end
    end

    // Data select for the granted input.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < int'(NUM_IN); i++) begin
            if (grant == SEL_W'(i)) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next state of the output stage: load, drain to empty, or hold.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_src_d   = out_src_q;
        if (load_en) begin
            if (gvalid) begin
                out_data_d  = sel_data;
                out_src_d   = grant;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // Output register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux_rr_nbyw.sv
// Self-checking bench: three instances (RR 4x64, SEL 4x64, RR 3x8) against a queue-free
// behavioural model of the output slot and the circular grant order.
module tb_mux_rr_nbyw;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] data_ab;
    logic [3:0]   v_ab;
    logic         rdy_a, rdy_b, rdy_c;
    logic [1:0]   sel_a, sel_b, sel_c;
    logic [23:0]  data_c;
    logic [2:0]   v_c;

    logic [3:0]  rdyo_a, rdyo_b;
    logic [2:0]  rdyo_c;
    logic [63:0] od_a, od_b;
    logic [7:0]  od_c;
    logic        ov_a, ov_b, ov_c;
    logic [1:0]  os_a, os_b, os_c;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mux_rr_nbyw #(.WIDTH(64), .NUM_IN(4), .MODE(1)) dut_a (
        .clk(clk), .rst(rst), .in_data(data_ab), .in_valid(v_ab), .in_ready(rdyo_a),
        .sel(sel_a), .out_data(od_a), .out_valid(ov_a), .out_ready(rdy_a), .out_src(os_a)
    );

    mux_rr_nbyw #(.WIDTH(64), .NUM_IN(4), .MODE(0)) dut_b (
        .clk(clk), .rst(rst), .in_data(data_ab), .in_valid(v_ab), .in_ready(rdyo_b),
        .sel(sel_b), .out_data(od_b), .out_valid(ov_b), .out_ready(rdy_b), .out_src(os_b)
    );

    mux_rr_nbyw #(.WIDTH(8), .NUM_IN(3), .MODE(1)) dut_c (
        .clk(clk), .rst(rst), .in_data(data_c), .in_valid(v_c), .in_ready(rdyo_c),
        .sel(sel_c), .out_data(od_c), .out_valid(ov_c), .out_ready(rdy_c), .out_src(os_c)
    );

    // Model state per instance: 0 = dut_a, 1 = dut_b, 2 = dut_c.
    bit          m_valid[3];
    logic [63:0] m_data[3];
    int          m_src[3];
    int          m_ptr[3];
    int          g[3];
    bit          le[3];
    int          nin[3] = '{4, 4, 3};
    int          wid[3] = '{64, 64, 8};
    bit          rr[3]  = '{1'b1, 1'b0, 1'b1};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_valid[d] = 1'b0;
            m_data[d]  = '0;
            m_src[d]   = 0;
            m_ptr[d]   = 0;
        end
    endtask

    // Winner under the rules: circular search from ptr, or the selected input if it is valid.
    function automatic int pick(input int d, input logic [3:0] v, input int s);
        int idx;
        if (rr[d]) begin
            for (int k = 0; k < nin[d]; k++) begin
                idx = (m_ptr[d] + k) % nin[d];
                if (v[idx]) return idx;
            end
            return -1;
        end
        return (s < nin[d] && v[s]) ? s : -1;
    endfunction

    task automatic pre(input int d, input logic [3:0] v, input int s, input bit ordy,
                       input logic [3:0] got_rdy);
        logic [3:0] exp;
        le[d] = !m_valid[d] || ordy;
        g[d]  = le[d] ? pick(d, v, s) : -1;
        exp   = (g[d] >= 0) ? (4'b0001 << g[d]) : 4'b0000;
        check($sformatf("in_ready[%0d]", d), {60'b0, got_rdy}, {60'b0, exp});
    endtask

    task automatic post(input int d, input logic [255:0] data, input logic got_v,
                        input logic [63:0] got_d, input logic [1:0] got_s);
        logic [255:0] tmp;
        if (le[d]) begin
            if (g[d] >= 0) begin
                tmp = data >> (g[d] * wid[d]);
                if (wid[d] == 8) tmp = tmp & 256'hFF;
                m_data[d]  = tmp[63:0];
                m_src[d]   = g[d];
                m_valid[d] = 1'b1;
                if (rr[d]) m_ptr[d] = (g[d] + 1) % nin[d];
            end else begin
                m_valid[d] = 1'b0;
            end
        end
        check($sformatf("out_valid[%0d]", d), {63'b0, got_v}, {63'b0, m_valid[d]});
        check($sformatf("out_data[%0d]", d), got_d, m_data[d]);
        check($sformatf("out_src[%0d]", d), {62'b0, got_s}, 64'(m_src[d]));
    endtask

    // Called just after a falling edge with inputs already driven; returns at the next one.
    task automatic tick();
        #1;
        pre(0, v_ab, 0, rdy_a, rdyo_a);
        pre(1, v_ab, int'(sel_b), rdy_b, rdyo_b);
        pre(2, {1'b0, v_c}, 0, rdy_c, {1'b0, rdyo_c});
        @(posedge clk);
        #1;
        post(0, data_ab, ov_a, od_a, os_a);
        post(1, data_ab, ov_b, od_b, os_b);
        post(2, {232'b0, data_c}, ov_c, {56'b0, od_c}, os_c);
        @(negedge clk);
    endtask

    task automatic set_ready(input logic r);
        rdy_a = r;
        rdy_b = r;
        rdy_c = r;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ov_a"}, {63'b0, ov_a}, 64'd0);
        check({tag, " od_a"}, od_a, 64'd0);
        check({tag, " os_a"}, {62'b0, os_a}, 64'd0);
        check({tag, " ov_b"}, {63'b0, ov_b}, 64'd0);
        check({tag, " ov_c"}, {63'b0, ov_c}, 64'd0);
        check({tag, " od_c"}, {56'b0, od_c}, 64'd0);
        check({tag, " rdy_a"}, {60'b0, rdyo_a}, 64'd0);
        check({tag, " rdy_c"}, {61'b0, rdyo_c}, 64'd0);
    endtask

    initial begin
        rst     = 1'b1;
        data_ab = '0;
        v_ab    = '0;
        data_c  = '0;
        v_c     = '0;
        sel_a   = '0;
        sel_b   = '0;
        sel_c   = '0;
        set_ready(1'b1);
        model_reset();
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle: nothing valid, nothing happens.
        tick();
        tick();

        // External select: input 2 goes through on sel=2.
        sel_b   = 2'd2;
        v_ab    = 4'b0100;
        data_ab[128 +: 64] = 64'hDEAD_BEEF_0000_0002;
        tick();
        check("sel2 data", od_b, 64'hDEAD_BEEF_0000_0002);
        check("sel2 src", {62'b0, os_b}, 64'd2);

        // sel=3 with input 3 idle: no transfer, register empties.
        sel_b = 2'd3;
        tick();
        check("sel3 empty", {63'b0, ov_b}, 64'd0);

        // Fairness: every input valid, data = index.
        for (int i = 0; i < 4; i++) data_ab[i*64 +: 64] = 64'(i);
        v_ab = 4'b1111;
        for (int i = 0; i < 8; i++) tick();

        // Backpressure on the RR instance, then release.
        rdy_a = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rdy_a = 1'b1;
        tick();

        // Three-input skip/wrap: land ptr at 2, then grant 0, then grant 1.
        v_c    = 3'b010;
        data_c = 24'h33_22_11;
        tick();
        v_c = 3'b001;
        tick();
        check("wrap grant0", {62'b0, os_c}, 64'd0);
        v_c = 3'b110;
        tick();
        check("skip grant1", {62'b0, os_c}, 64'd1);

        // Drain with nobody requesting.
        v_ab = '0;
        v_c  = '0;
        tick();
        check("drain empty", {63'b0, ov_a}, 64'd0);

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 8; i++) data_ab[i*32 +: 32] = $urandom;
            data_c = 24'($urandom);
            v_ab   = 4'($urandom);
            v_c    = 3'($urandom);
            sel_b  = 2'($urandom_range(0, 3));
            rdy_a  = ($urandom_range(0, 9) < 7);
            rdy_b  = ($urandom_range(0, 9) < 7);
            rdy_c  = ($urandom_range(0, 9) < 7);
            tick();
        end

        // Reset mid-operation with everything full and inputs still requesting.
        v_ab  = 4'b1111;
        v_c   = 3'b111;
        sel_b = 2'd1;
        set_ready(1'b1);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(negedge clk);
        rst  = 1'b0;
        v_ab = '0;
        v_c  = '0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
